// File: rtl/force_cache_accumulator.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// force_cache_accumulator
//
// Purpose:
//    Per-particle force cache. Force packets arriving from the ring are
//    buffered in a small FIFO and accumulated into a block-RAM slot addressed
//    by particle id. The motion-update unit reads a slot, which returns the
//    accumulated {fz,fy,fx} and clears that slot to zero. After reset an INIT
//    sweep zeroes every slot before normal operation starts.
//
// Ports:
//    clk                 rising-edge clock
//    rst                 asynchronous active-high reset
//    force_wr_enable     ring delivers a packet this cycle (no backpressure)
//    force_and_addr_in   {fz, fy, fx, slot_id}
//    mu_rd_request       motion-update read-and-clear request
//    mu_rd_addr          slot to read
//    force_to_MU         {fz, fy, fx} of the requested slot
//    force_id_to_MU      slot id belonging to force_to_MU
//    force_valid_to_MU   force_to_MU / force_id_to_MU valid
//    input_buffer_empty  FIFO empty and no accumulation in flight
//    init_done           clear sweep complete
//    overflow            sticky: a packet was dropped on a full FIFO
// -----------------------------------------------------------------------------
module force_cache_accumulator #(
   parameter int DATA_WIDTH        = 32,
   parameter int PARTICLE_ID_WIDTH = 7,
   parameter int FORCE_CACHE_DEPTH = 100,
   parameter int FIFO_DEPTH        = 8,
   parameter int FORCE_DATA_WIDTH  = PARTICLE_ID_WIDTH + 3*DATA_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         force_wr_enable,
   input  logic [FORCE_DATA_WIDTH-1:0]  force_and_addr_in,
   input  logic                         mu_rd_request,
   input  logic [PARTICLE_ID_WIDTH-1:0] mu_rd_addr,
   output logic [3*DATA_WIDTH-1:0]      force_to_MU,
   output logic [PARTICLE_ID_WIDTH-1:0] force_id_to_MU,
   output logic                         force_valid_to_MU,
   output logic                         input_buffer_empty,
   output logic                         init_done,
   output logic                         overflow
);

   localparam int FW  = 3*DATA_WIDTH;
   localparam int PID = PARTICLE_ID_WIDTH;
   localparam int FAW = $clog2(FIFO_DEPTH);

   localparam logic [FAW:0]   FIFO_FULL_COUNT = (FAW+1)'(FIFO_DEPTH);
   localparam logic [PID:0]   DEPTH_LIMIT     = (PID+1)'(FORCE_CACHE_DEPTH);
   localparam logic [PID-1:0] SWEEP_LAST      = PID'(FORCE_CACHE_DEPTH-1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t r_state;
   state_t w_state_next;
   logic [PID-1:0] r_sweep_cnt;

   // Input FIFO (small, combinational read of the head entry)
   logic [FORCE_DATA_WIDTH-1:0] r_fifo_mem [FIFO_DEPTH];
   logic [FAW-1:0]              r_wr_ptr;
   logic [FAW-1:0]              r_rd_ptr;
   logic [FAW:0]                r_count;
   logic                        r_overflow;

   logic                        w_fifo_empty;
   logic                        w_fifo_full;
   logic                        w_push;
   logic                        w_pop;
   logic                        w_drop;
   logic [FORCE_DATA_WIDTH-1:0] w_head;
   logic [PID-1:0]              w_head_id;
   logic                        w_head_in_range;

   // Force cache RAM with registered read
   logic [FW-1:0]  r_ram [FORCE_CACHE_DEPTH];
   logic [FW-1:0]  r_ram_rd_data;
   logic [PID-1:0] w_rd_addr;
   logic           w_we;
   logic [PID-1:0] w_waddr;
   logic [FW-1:0]  w_wdata;

   // Second pipeline stage: accumulate or motion-update clear
   logic           r_acc_valid;
   logic [PID-1:0] r_acc_addr;
   logic [FW-1:0]  r_acc_force;
   logic           r_mu_valid;
   logic [PID-1:0] r_mu_addr;
   logic           r_mu_in_range;
   logic           r_byp_hit;
   logic [FW-1:0]  r_byp_data;

   logic           w_mu_req;
   logic           w_mu_in_range;
   logic [FW-1:0]  w_old;
   logic [FW-1:0]  w_sum;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_sweep_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_INIT) begin
            r_sweep_cnt <= r_sweep_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_INIT: if (r_sweep_cnt == SWEEP_LAST) w_state_next = ST_RUN;
         ST_RUN:  w_state_next = ST_RUN;
         default: w_state_next = ST_INIT;
      endcase
   end

   // ---------------------------------------------------------------- FIFO
   assign w_fifo_empty    = (r_count == '0);
   assign w_fifo_full     = (r_count == FIFO_FULL_COUNT);
   assign w_head          = r_fifo_mem[r_rd_ptr];
   assign w_head_id       = w_head[PID-1:0];
   assign w_head_in_range = ({1'b0, w_head_id} < DEPTH_LIMIT);

   assign w_mu_req      = (r_state == ST_RUN) && mu_rd_request;
   assign w_mu_in_range = ({1'b0, mu_rd_addr} < DEPTH_LIMIT);

   // A clear occupies the write port in the cycle after an MU read, so no
   // pop is issued while that clear is pending; MU requests also take the
   // single read port, so they win over pops.
   assign w_pop  = (r_state == ST_RUN) && !w_fifo_empty && !mu_rd_request && !r_mu_valid;
   // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
   assign w_push = force_wr_enable && (!w_fifo_full || w_pop);
   assign w_drop = force_wr_enable && !w_push;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_fifo_mem[r_wr_ptr] <= force_and_addr_in;
   end

   // ---------------------------------------------------------------- RAM
   assign w_rd_addr = w_mu_req ? mu_rd_addr : w_head_id;

   // Single write port: the INIT sweep, then a pending clear, then an
   // accumulate. The pop rules guarantee the last two never coincide.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_acc_addr;
      w_wdata = w_sum;
      if (r_state == ST_INIT) begin
         w_we    = 1'b1;
         w_waddr = r_sweep_cnt;
         w_wdata = '0;
      end else if (r_mu_valid) begin
         w_we    = r_mu_in_range;
         w_waddr = r_mu_addr;
         w_wdata = '0;
      end else if (r_acc_valid) begin
         w_we    = 1'b1;
         w_waddr = r_acc_addr;
         w_wdata = w_sum;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) r_ram[w_waddr] <= w_wdata;
   end

   always_ff @(posedge clk) begin
      r_ram_rd_data <= r_ram[w_rd_addr];
   end

   // ---------------------------------------------------------------- stage 2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc_valid   <= 1'b0;
         r_acc_addr    <= '0;
         r_acc_force   <= '0;
         r_mu_valid    <= 1'b0;
         r_mu_addr     <= '0;
         r_mu_in_range <= 1'b0;
         r_byp_hit     <= 1'b0;
         r_byp_data    <= '0;
      end else begin
         // Out-of-range packets are popped and silently discarded.
         r_acc_valid   <= w_pop && w_head_in_range;
         r_acc_addr    <= w_head_id;
         r_acc_force   <= w_head[PID +: FW];
         r_mu_valid    <= w_mu_req;
         r_mu_addr     <= mu_rd_addr;
         r_mu_in_range <= w_mu_in_range;
         // RAM read returns pre-write data; remember a same-address write
         // so the next cycle sees the freshly written value instead.
         r_byp_hit     <= w_we && (w_waddr == w_rd_addr);
         r_byp_data    <= w_wdata;
      end
   end

   assign w_old = r_byp_hit ? r_byp_data : r_ram_rd_data;

   // Per-component wrap-around addition
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_comp
         assign w_sum[gi*DATA_WIDTH +: DATA_WIDTH] =
            w_old[gi*DATA_WIDTH +: DATA_WIDTH] + r_acc_force[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // ---------------------------------------------------------------- outputs
   assign force_valid_to_MU  = r_mu_valid;
   assign force_to_MU        = (r_mu_valid && r_mu_in_range) ? w_old : '0;
   assign force_id_to_MU     = r_mu_valid ? r_mu_addr : '0;
   assign input_buffer_empty = w_fifo_empty && !r_acc_valid;
   assign init_done          = (r_state == ST_RUN);
   assign overflow           = r_overflow;

endmodule
